// File: rtl/mode_pkg.sv
// Shared encodings for the moding driver: command ops, control states and drive phases.
package mode_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_ZERO    = 3'd1,
    OP_CA_ON   = 3'd2,
    OP_CA_OFF  = 3'd3,
    OP_EEC_ON  = 3'd4,
    OP_EEC_OFF = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2,
    ST_ZERO  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_1 = 2'd0,
    PH_2 = 2'd1,
    PH_3 = 2'd2,
    PH_4 = 2'd3
  } phase_e;

  localparam logic [2:0] OP_LAST_LEGAL = 3'd5;

  // Codes 6 and 7 are reserved and rejected on acceptance.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/mode_driver_if.sv
// Moding command handshake between a command source and the mode driver.
interface mode_driver_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;
  logic       cmd_err;

  modport master (output cmd_valid, output cmd_op, input cmd_ready, input cmd_err);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready, output cmd_err);
endinterface

// File: rtl/mode_phase_gen.sv
// Free-running four-phase generator: clk divider, phase counter, active-low phase drives,
// cycle_start, and a boundary_c strobe that is high in the clk before phase 1 is entered.
module mode_phase_gen
  import mode_pkg::*;
#(
  parameter int unsigned DIVIDE = 4
) (
  input  logic clk,
  input  logic rst,
  output logic faz2dr,
  output logic faz3dr,
  output logic faz4dr,
  output logic faz2dr_n,
  output logic cycle_start,
  output logic boundary_c
);

  localparam int unsigned CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           phase_q, phase_d;

  // Reset parks on the last count of phase 4 so the first edge out of reset enters phase 1.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = phase_e'(2'(phase_q) + 2'd1);
    end
  end

  assign boundary_c = (phase_q == PH_4) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= CNT_LAST;
      phase_q     <= PH_4;
      faz2dr      <= 1'b1;
      faz3dr      <= 1'b1;
      faz4dr      <= 1'b1;
      faz2dr_n    <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      faz2dr      <= (phase_d != PH_2);
      faz3dr      <= (phase_d != PH_3);
      faz4dr      <= (phase_d != PH_4);
      faz2dr_n    <= (phase_d == PH_2);
      cycle_start <= boundary_c;
    end
  end

endmodule

// File: rtl/mode_driver.sv
// Moding driver: accepts one command at a time and applies it on the next phase-1 boundary.
// Optional MODE_DRIVER_INTERLOCK_EN couples coarse-align and error-counter-enable discretes.
module mode_driver
  import mode_pkg::*;
#(
  parameter int unsigned DIVIDE   = 4,
  parameter int unsigned ZERO_LEN = 2
) (
  input  logic          clk,
  input  logic          rst,
  mode_driver_if.slave  cmd,
  output logic          FAZ2DR,
  output logic          FAZ3DR,
  output logic          FAZ4DR,
  output logic          FAZ2DR_n,
  output logic          AGCCA,
  output logic          AGCZ,
  output logic          AGCEEC,
  output logic          ISSZDR,
  output logic          cycle_start
);

  localparam int unsigned ZCNT_W = (ZERO_LEN > 1) ? $clog2(ZERO_LEN) : 1;
  localparam logic [ZCNT_W-1:0] ZCNT_LAST = ZCNT_W'(ZERO_LEN - 1);

  state_e            state_q, state_d;
  op_e               pend_q, pend_d;
  logic [ZCNT_W-1:0] zcnt_q, zcnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              ca_d, eec_d, zero_d;
  logic              boundary;
  logic              accept, reject;

  mode_phase_gen #(.DIVIDE(DIVIDE)) u_phase (
    .clk         (clk),
    .rst         (rst),
    .faz2dr      (FAZ2DR),
    .faz3dr      (FAZ3DR),
    .faz4dr      (FAZ4DR),
    .faz2dr_n    (FAZ2DR_n),
    .cycle_start (cycle_start),
    .boundary_c  (boundary)
  );

  assign cmd.cmd_ready = ready_q;
  assign cmd.cmd_err   = err_q;
  assign accept        = cmd.cmd_valid && ready_q;

  // Commands rejected at acceptance never reach the pending register.
  always_comb begin
    reject = !op_legal(cmd.cmd_op);
`ifdef MODE_DRIVER_INTERLOCK_EN
    if ((cmd.cmd_op == OP_EEC_ON) && !AGCCA) reject = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= OP_NOP;
      zcnt_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      AGCCA   <= 1'b1;
      AGCEEC  <= 1'b1;
      AGCZ    <= 1'b1;
      ISSZDR  <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zcnt_q  <= zcnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      AGCCA   <= ca_d;
      AGCEEC  <= eec_d;
      AGCZ    <= zero_d;
      ISSZDR  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !reject) state_d = ST_PEND;
      ST_PEND:  if (boundary) state_d = ST_APPLY;
      ST_APPLY: state_d = (pend_q == OP_ZERO) ? ST_ZERO : ST_IDLE;
      ST_ZERO:  if (boundary && (zcnt_q == ZCNT_LAST)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Mode discretes only move on a boundary edge, while in PEND or ZERO.
  always_comb begin
    pend_d  = pend_q;
    zcnt_d  = zcnt_q;
    ca_d    = AGCCA;
    eec_d   = AGCEEC;
    zero_d  = AGCZ;
    err_d   = accept && reject;
    ready_d = (state_d == ST_IDLE) && !err_d;
    case (state_q)
      ST_IDLE: if (accept && !reject) pend_d = op_e'(cmd.cmd_op);
      ST_PEND: begin
        if (boundary) begin
          case (pend_q)
            OP_ZERO: begin
              zero_d = 1'b0;
              zcnt_d = '0;
            end
            OP_CA_ON: begin
              ca_d = 1'b0;
`ifdef MODE_DRIVER_INTERLOCK_EN
              eec_d = 1'b1;
`endif
            end
            OP_CA_OFF:  ca_d  = 1'b1;
            OP_EEC_ON:  eec_d = 1'b0;
            OP_EEC_OFF: eec_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_APPLY: pend_d = OP_NOP;
      ST_ZERO: begin
        if (boundary) begin
          if (zcnt_q == ZCNT_LAST) zero_d = 1'b1;
          else                     zcnt_d = zcnt_q + ZCNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
